// File: rtl/ov7670_frame_writer.sv
// ov7670_frame_writer: OV7670 RGB565 capture -> RGB332 frame-buffer writes at y*SCREEN_WIDTH+x
// Ports: CLK system clock (>= 4x CAM_PCLK); RESET_N async active-low reset;
//        CAM_PCLK/CAM_HREF/CAM_VSYNC/CAM_DATA raw camera bus (asynchronous to CLK);
//        W_EN/W_ADDR/W_DATA one-cycle pixel write; FRAME_DONE end-of-frame pulse;
//        FRAME_ERR short line/frame flag for the last completed frame.
// Option: define TEST_PATTERN_EN to replace camera pixels with 8 colour bars (x/22).
module ov7670_frame_writer #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CAM_PCLK,
    input  logic              CAM_HREF,
    input  logic              CAM_VSYNC,
    input  logic [7:0]        CAM_DATA,
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR
);
    localparam int XW = $clog2(SCREEN_WIDTH + 1);
    localparam int YW = $clog2(SCREEN_HEIGHT + 2);
    localparam logic [XW-1:0]     X_MAX     = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0]     Y_MAX     = YW'(SCREEN_HEIGHT);
    localparam logic [YW-1:0]     Y_SAT     = YW'(SCREEN_HEIGHT + 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SCREEN_WIDTH);

    typedef enum logic {WAIT_FRAME, CAPTURE} state_t;

    state_t state_q, state_d;
    logic [2:0] pclk_q, href_q, vsync_q;
    logic [7:0] data1_q, data2_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d, line_q, line_d, waddr_d;
    logic [5:0] hi_q, hi_d;
    logic phase_q, phase_d, err_q, err_d;
    logic wen_d, done_d, ferr_d;
    logic [7:0] wdata_d, pix;
    logic pclk_rise, href_fall, vsync_rise, vsync_fall;

    // bit 1 is the second synchroniser stage, bit 2 the edge-detect stage
    assign pclk_rise  = pclk_q[1] & ~pclk_q[2];
    assign href_fall  = href_q[2] & ~href_q[1];
    assign vsync_rise = vsync_q[1] & ~vsync_q[2];
    assign vsync_fall = vsync_q[2] & ~vsync_q[1];

`ifdef TEST_PATTERN_EN
    localparam logic [63:0] BARS = {8'h00, 8'hFF, 8'h1F, 8'hE3, 8'hFC, 8'h03, 8'h1C, 8'hE0};
    logic [XW-1:0] bar;
    logic [2:0] bar_sel;
    assign bar     = x_q / XW'(22);
    assign bar_sel = (bar > XW'(7)) ? 3'd7 : bar[2:0];
    assign pix     = BARS[{bar_sel, 3'b000} +: 8];
`else
    assign pix = {hi_q, data2_q[4:3]};
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= WAIT_FRAME;
            pclk_q     <= '0;
            href_q     <= '0;
            vsync_q    <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            hi_q       <= '0;
            phase_q    <= 1'b0;
            err_q      <= 1'b0;
            W_EN       <= 1'b0;
            W_ADDR     <= '0;
            W_DATA     <= '0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pclk_q     <= {pclk_q[1:0], CAM_PCLK};
            href_q     <= {href_q[1:0], CAM_HREF};
            vsync_q    <= {vsync_q[1:0], CAM_VSYNC};
            data1_q    <= CAM_DATA;
            data2_q    <= data1_q;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            hi_q       <= hi_d;
            phase_q    <= phase_d;
            err_q      <= err_d;
            W_EN       <= wen_d;
            W_ADDR     <= waddr_d;
            W_DATA     <= wdata_d;
            FRAME_DONE <= done_d;
            FRAME_ERR  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_FRAME && vsync_fall) state_d = CAPTURE;
        if (state_q == CAPTURE && vsync_rise) state_d = WAIT_FRAME;
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        line_d  = line_q;
        hi_d    = hi_q;
        phase_d = phase_q;
        err_d   = err_q;
        wen_d   = 1'b0;
        waddr_d = W_ADDR;
        wdata_d = W_DATA;
        done_d  = 1'b0;
        ferr_d  = FRAME_ERR;
        if (state_q == WAIT_FRAME) begin
            if (vsync_fall) begin
                x_d     = '0;
                y_d     = '0;
                addr_d  = '0;
                line_d  = '0;
                phase_d = 1'b0;
                err_d   = 1'b0;
            end
        end else begin
            if (pclk_rise && href_q[1]) begin
                phase_d = ~phase_q;
                if (!phase_q) hi_d = {data2_q[7:5], data2_q[2:0]};
                else if (x_q < X_MAX) begin
                    // x saturates at the line width so overlong lines stop writing
                    x_d = x_q + 1'b1;
                    if (y_q < Y_MAX) begin
                        wen_d   = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = pix;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            // line end is resolved before a coincident frame end so its y/err count
            if (href_fall) begin
                phase_d = 1'b0;
                if (x_q != '0) begin
                    err_d = err_q | (x_q != X_MAX);
                    y_d   = (y_q == Y_SAT) ? y_q : y_q + 1'b1;
                    x_d   = '0;
                    if (y_q < Y_MAX) begin
                        line_d = line_q + LINE_STEP;
                        addr_d = line_q + LINE_STEP;
                    end
                end
            end
            if (vsync_rise) begin
                done_d = 1'b1;
                ferr_d = err_d | (y_d != Y_MAX);
            end
        end
    end
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// tb_ov7670_frame_writer: randomized scenarios against a frame-level reference model
`timescale 1ns/1ps
module tb_ov7670_frame_writer;
    localparam int W  = 24;
    localparam int H  = 12;
    localparam int AW = 9;

    logic CLK = 0, RESET_N = 0, CAM_PCLK = 0, CAM_HREF = 0, CAM_VSYNC = 0;
    logic [7:0] CAM_DATA = 0;
    logic W_EN, FRAME_DONE, FRAME_ERR;
    logic [AW-1:0] W_ADDR;
    logic [7:0] W_DATA;

    ov7670_frame_writer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CAM_PCLK(CAM_PCLK), .CAM_HREF(CAM_HREF),
        .CAM_VSYNC(CAM_VSYNC), .CAM_DATA(CAM_DATA), .W_EN(W_EN), .W_ADDR(W_ADDR),
        .W_DATA(W_DATA), .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    logic [AW+7:0] cap[$], exp_q[$];
    int done_cnt = 0, b2b = 0;
    logic last_err = 0, prev_wen = 0;
    int my_y = 0;
    bit my_err = 0, fix_en = 0;
    logic [7:0] fix0 = 0, fix1 = 0;

    always @(negedge CLK) begin
        if (W_EN) cap.push_back({W_ADDR, W_DATA});
        if (W_EN && prev_wen) b2b++;
        prev_wen = W_EN;
        if (FRAME_DONE) begin
            done_cnt++;
            last_err = FRAME_ERR;
        end
    end

    function automatic logic [7:0] pack(input logic [7:0] b0, input logic [7:0] b1, input int x);
`ifdef TEST_PATTERN_EN
        logic [7:0] bars [8] = '{8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'hFF, 8'h00};
        return bars[x / 22];
`else
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = b0[7:3];
        g = {b0[2:0], b1[7:5]};
        b = b1[4:0];
        return {r[4:2], g[5:3], b[4:3]};
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        CAM_DATA = b;
        tick(2);
        CAM_PCLK = 1;
        tick(2);
        CAM_PCLK = 0;
    endtask

    task automatic send_line(input int npix, input bit odd);
        logic [7:0] b0, b1;
        CAM_HREF = 1;
        for (int p = 0; p < npix; p++) begin
            b0 = fix_en ? fix0 : 8'($urandom);
            b1 = fix_en ? fix1 : 8'($urandom);
            send_byte(b0);
            send_byte(b1);
            if (p < W && my_y < H) exp_q.push_back({AW'(my_y * W + p), pack(b0, b1, p)});
        end
        if (odd) send_byte(8'($urandom));
        CAM_HREF = 0;
        tick(6);
        if (npix > 0) begin
            if (npix < W) my_err = 1;
            my_y++;
        end
    endtask

    task automatic frame_begin();
        CAM_VSYNC = 1;
        tick(6);
        cap.delete();
        exp_q.delete();
        done_cnt = 0;
        my_y = 0;
        my_err = 0;
        CAM_VSYNC = 0;
        tick(6);
    endtask

    task automatic frame_end();
        CAM_VSYNC = 1;
        tick(8);
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if ({W_EN, FRAME_DONE, FRAME_ERR} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000", {W_EN, FRAME_DONE, FRAME_ERR});
        end
        frame_begin();
        send_line(4, 0);
        send_line(3, 1);
        frame_end();
        checks++;
        if (cap.size() != 0 || done_cnt != 0 || FRAME_ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got writes=%0d done=%0d err=%b want 0 0 0", cap.size(), done_cnt, FRAME_ERR);
        end
        CAM_VSYNC = 0;
        tick(6);
        RESET_N = 1;
        tick(6);
        cap.delete();
        send_line(5, 0);
        send_line(W, 0);
        CAM_VSYNC = 1;
        tick(8);
        checks++;
        if (cap.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL no_vsync_fall got writes=%0d done=%0d want 0 0", cap.size(), done_cnt);
        end
    endtask

    task automatic test_full_frame();
        fix_en = 1;
        fix0 = 8'hF8;
        fix1 = 8'h00;
        frame_begin();
        for (int l = 0; l < H; l++) send_line(W, 0);
        frame_end();
        fix_en = 0;
        checks++;
        if (cap.size() != W * H) begin
            errors++;
            $display("FAIL full_count got %0d want %0d", cap.size(), W * H);
        end
        foreach (exp_q[i]) if (i < cap.size()) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_write[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
`ifndef TEST_PATTERN_EN
        checks++;
        if (cap.size() > 0 && cap[0][7:0] !== 8'hE0) begin
            errors++;
            $display("FAIL full_red got %h want e0", cap[0][7:0]);
        end
`endif
        checks++;
        if (done_cnt != 1 || last_err !== 1'b0) begin
            errors++;
            $display("FAIL full_done got done=%0d err=%b want 1 0", done_cnt, last_err);
        end
    endtask

    task automatic test_latency();
        logic [3:0] seen;
        logic [7:0] d3;
        seen = '0;
        d3 = '0;
        frame_begin();
        CAM_HREF = 1;
        send_byte(8'h07);
        CAM_DATA = 8'hFF;
        tick(2);
        CAM_PCLK = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            #1;
            seen[k] = W_EN;
            if (W_EN) d3 = W_DATA;
        end
        @(negedge CLK);
        tick(1);
        CAM_PCLK = 0;
        exp_q.push_back({AW'(0), pack(8'h07, 8'hFF, 0)});
        send_byte(8'h00);
        send_byte(8'h1F);
        exp_q.push_back({AW'(1), pack(8'h00, 8'h1F, 1)});
        CAM_HREF = 0;
        tick(6);
        frame_end();
        checks++;
        if (seen !== 4'b0100) begin
            errors++;
            $display("FAIL latency_wen got %b want 0100", seen);
        end
        checks++;
        if (d3 !== pack(8'h07, 8'hFF, 0)) begin
            errors++;
            $display("FAIL latency_data got %h want %h", d3, pack(8'h07, 8'hFF, 0));
        end
        checks++;
        if (cap.size() != 2) begin
            errors++;
            $display("FAIL latency_count got %0d want 2", cap.size());
        end
        foreach (exp_q[i]) if (i < cap.size()) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL latency_write[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || last_err !== 1'b1) begin
            errors++;
            $display("FAIL latency_done got done=%0d err=%b want 1 1", done_cnt, last_err);
        end
    endtask

    task automatic test_clip();
        frame_begin();
        send_line(W + 4, 1);
        for (int l = 1; l < H; l++) send_line(W, 0);
        frame_end();
        checks++;
        if (cap.size() != W * H) begin
            errors++;
            $display("FAIL clip_count got %0d want %0d", cap.size(), W * H);
        end
        checks++;
        if (cap.size() > W && cap[W][AW+7:8] !== AW'(W)) begin
            errors++;
            $display("FAIL clip_line1 got %0d want %0d", cap[W][AW+7:8], W);
        end
        foreach (exp_q[i]) if (i < cap.size()) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL clip_write[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || last_err !== 1'b0) begin
            errors++;
            $display("FAIL clip_done got done=%0d err=%b want 1 0", done_cnt, last_err);
        end
    endtask

    task automatic test_short_frame();
        frame_begin();
        for (int l = 0; l < H - 4; l++) begin
            send_line(W, 0);
            if (l == 2) send_line(0, 1);
        end
        frame_end();
        checks++;
        if (cap.size() != W * (H - 4) || (cap.size() > 0 && cap[cap.size()-1][AW+7:8] !== AW'(W * (H - 4) - 1))) begin
            errors++;
            $display("FAIL short_last got count=%0d want %0d", cap.size(), W * (H - 4));
        end
        foreach (exp_q[i]) if (i < cap.size()) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL short_write[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || last_err !== 1'b1) begin
            errors++;
            $display("FAIL short_done got done=%0d err=%b want 1 1", done_cnt, last_err);
        end
        frame_begin();
        for (int l = 0; l < H; l++) send_line(W, 0);
        frame_end();
        checks++;
        if (cap.size() != W * H || done_cnt != 1 || last_err !== 1'b0) begin
            errors++;
            $display("FAIL recover got count=%0d done=%0d err=%b want %0d 1 0", cap.size(), done_cnt, last_err, W * H);
        end
    endtask

    task automatic test_reset_mid();
        frame_begin();
        send_line(W, 0);
        frame_end();
        checks++;
        if (FRAME_ERR !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_err got %b want 1", FRAME_ERR);
        end
        frame_begin();
        for (int l = 0; l < 5; l++) send_line(W, 0);
        CAM_HREF = 1;
        send_byte(8'h12);
        send_byte(8'h34);
        RESET_N = 0;
        #1;
        checks++;
        if ({W_EN, FRAME_DONE, FRAME_ERR} !== 3'b000 || W_ADDR !== '0 || W_DATA !== '0) begin
            errors++;
            $display("FAIL reset_mid got en/done/err=%b addr=%0d data=%h want 000 0 00", {W_EN, FRAME_DONE, FRAME_ERR}, W_ADDR, W_DATA);
        end
        tick(3);
        cap.delete();
        done_cnt = 0;
        RESET_N = 1;
        for (int p = 0; p < 6; p++) send_byte(8'($urandom));
        CAM_HREF = 0;
        tick(6);
        for (int l = 0; l < 3; l++) send_line(W, 0);
        frame_end();
        checks++;
        if (cap.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL reset_partial got writes=%0d done=%0d want 0 0", cap.size(), done_cnt);
        end
        frame_begin();
        for (int l = 0; l < H; l++) send_line(W, 0);
        frame_end();
        checks++;
        if (cap.size() != W * H || (cap.size() > 0 && cap[0][AW+7:8] !== '0)) begin
            errors++;
            $display("FAIL reset_restart got count=%0d want %0d from addr 0", cap.size(), W * H);
        end
        foreach (exp_q[i]) if (i < cap.size()) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_write[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int nl, np;
        for (int f = 0; f < 3; f++) begin
            frame_begin();
            nl = $urandom_range(H - 2, H + 2);
            for (int l = 0; l < nl; l++) begin
                np = ($urandom_range(0, 2) == 0) ? $urandom_range(0, W + 3) : W;
                send_line(np, 1'($urandom));
            end
            frame_end();
            checks++;
            if (cap.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d want %0d", f, cap.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < cap.size()) begin
                checks++;
                if (cap[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_write[%0d] got %h want %h", f, i, cap[i], exp_q[i]);
                end
            end
            checks++;
            if (done_cnt != 1 || last_err !== (my_err || my_y != H)) begin
                errors++;
                $display("FAIL rand%0d_done got done=%0d err=%b want 1 %b", f, done_cnt, last_err, my_err || my_y != H);
            end
        end
        checks++;
        if (b2b != 0) begin
            errors++;
            $display("FAIL back_to_back_wen got %0d want 0", b2b);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_latency();
        test_clip();
        test_short_frame();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
